// File: rtl/spi_slave_cmd_engine.sv
// SPI slave command engine: oversamples SCK/CS/MOSI in the system clock
// domain, decodes address/cmd/length/dummy headers and drives the CSR and
// bulk-write buses. CSR reads are returned over MISO.
module spi_slave_cmd_engine #(
    parameter int pAdrsBytes  = 4,
    parameter int pDummyBytes = 1,
    parameter int pCpol       = 0,
    parameter int pCpha       = 0,
    parameter int pBulkBytes  = 4,
    parameter int pMaxLen     = 2048,
    parameter int pSyncStages = 2,
    localparam int pAdrsBits  = pAdrsBytes * 8,
    localparam int pBulkBits  = pBulkBytes * 8
) (
    input  logic                 iSysClk,
    input  logic                 iSysRst,
    input  logic                 iSpiSck,
    input  logic                 iSpiCs,
    input  logic                 iSpiMosi,
    output logic                 oSpiMiso,
    output logic                 oSpiMisoEn,
    output logic [pAdrsBits-1:0] oCsrAdrs,
    output logic [31:0]          oCsrWd,
    output logic                 oCsrWEd,
    output logic                 oCsrREq,
    input  logic [31:0]          iCsrRd,
    input  logic                 iCsrREd,
    output logic [pAdrsBits-1:0] oBulkAdrs,
    output logic [pBulkBits-1:0] oBulkWd,
    output logic                 oBulkWEd,
    output logic                 oBulkVd,
    output logic [1:0]           oErr,
    input  logic                 iErrClr
);

    localparam logic [3:0] sIdle   = 4'd0;
    localparam logic [3:0] sAdrs   = 4'd1;
    localparam logic [3:0] sCmd    = 4'd2;
    localparam logic [3:0] sLen    = 4'd3;
    localparam logic [3:0] sDummy  = 4'd4;
    localparam logic [3:0] sCsrWr  = 4'd5;
    localparam logic [3:0] sCsrRd  = 4'd6;
    localparam logic [3:0] sBulk   = 4'd7;
    localparam logic [3:0] sDrain  = 4'd8;

    localparam logic                 kSckIdle   = (pCpol != 0);
    localparam logic [5:0]           kAdrsLast  = 6'(pAdrsBits - 1);
    localparam logic [5:0]           kDummyLast = 6'(pDummyBytes * 8 - 1);
    localparam logic [1:0]           kWordLast  = 2'(pBulkBytes - 1);
    localparam logic [pAdrsBits-1:0] kAdrsStep  = pAdrsBits'(pBulkBytes);

    logic [pSyncStages-1:0] sckSync, csSync, mosiSync;
    logic                   sckD, csD;
    logic [pSyncStages:0]   rstPipe;
    logic                   sckS, csS, mosiS, lead, trail;
    logic                   sampleEdge, shiftEdge, csFall, csRise;

    logic [3:0]           state, payState, hdrNext;
    logic [1:0]           hdrErr;
    logic [5:0]           bitCnt;
    logic [31:0]          sr, srNext, misoSr;
    logic [pAdrsBits-1:0] frameAdrs, bulkAdrs;
    logic [7:0]           cmd;
    logic [15:0]          lenCnt, lenField;
    logic [1:0]           byteIdx;
    logic                 rdPend, rdFirst, fieldLast;
    logic [pBulkBits-1:0] bulkWord;

    // Pin synchronisers; rstPipe masks the false CS edge while the chain refills after reset
    always_ff @(posedge iSysClk) begin
        if (!iSysRst) begin
            sckSync  <= {pSyncStages{kSckIdle}};
            csSync   <= '1;
            mosiSync <= '0;
            sckD     <= kSckIdle;
            csD      <= 1'b1;
            rstPipe  <= '0;
        end else begin
            sckSync  <= {sckSync[pSyncStages-2:0], iSpiSck};
            csSync   <= {csSync[pSyncStages-2:0], iSpiCs};
            mosiSync <= {mosiSync[pSyncStages-2:0], iSpiMosi};
            sckD     <= sckS;
            csD      <= csS;
            rstPipe  <= {rstPipe[pSyncStages-1:0], 1'b1};
        end
    end

    assign sckS       = sckSync[pSyncStages-1];
    assign csS        = csSync[pSyncStages-1];
    assign mosiS      = mosiSync[pSyncStages-1];
    assign lead       = (sckD == kSckIdle) && (sckS != kSckIdle);
    assign trail      = (sckD != kSckIdle) && (sckS == kSckIdle);
    assign sampleEdge = !csS && ((pCpha == 0) ? lead : trail);
    assign shiftEdge  = !csS && ((pCpha == 0) ? trail : lead);
    assign csFall     = rstPipe[pSyncStages] && csD && !csS;
    assign csRise     = !csD && csS;

    assign srNext   = {sr[30:0], mosiS};
    assign lenField = srNext[15:0];
    assign oSpiMiso = oSpiMisoEn & misoSr[31];

    // Last bit of the current header/payload field
    always_comb begin
        fieldLast = 1'b0;
        case (state)
            sAdrs:   fieldLast = (bitCnt == kAdrsLast);
            sCmd:    fieldLast = (bitCnt == 6'd7);
            sLen:    fieldLast = (bitCnt == 6'd15);
            sDummy:  fieldLast = (bitCnt == kDummyLast);
            sCsrWr:  fieldLast = (bitCnt == 6'd31);
            default: fieldLast = 1'b0;
        endcase
    end

    // Command/length check applied when the length field completes
    always_comb begin
        hdrNext = sDrain;
        hdrErr  = 2'd0;
        case (cmd)
            8'h00: hdrNext = sDrain;
            8'h01: if (lenField == 16'd4) hdrNext = sCsrWr; else hdrErr = 2'd2;
            8'h02: if (lenField == 16'd4) hdrNext = sCsrRd; else hdrErr = 2'd2;
            8'h03: begin
                if ({16'd0, lenField} > 32'(pMaxLen)) hdrErr = 2'd2;
                else if (lenField != 16'd0)          hdrNext = sBulk;
            end
            default: hdrErr = 2'd1;
        endcase
    end

    // Partial final word lands in the high bytes, zero-padded below
    always_comb begin
        bulkWord = srNext[pBulkBits-1:0] << (8 * (pBulkBytes - 1 - int'(byteIdx)));
    end

    // Frame FSM, bus strobes, MISO shifter and sticky error
    always_ff @(posedge iSysClk) begin
        if (!iSysRst) begin
            state      <= sIdle;
            payState   <= sDrain;
            bitCnt     <= '0;
            sr         <= '0;
            misoSr     <= '0;
            frameAdrs  <= '0;
            bulkAdrs   <= '0;
            cmd        <= '0;
            lenCnt     <= '0;
            byteIdx    <= '0;
            rdPend     <= 1'b0;
            rdFirst    <= 1'b0;
            oSpiMisoEn <= 1'b0;
            oCsrAdrs   <= '0;
            oCsrWd     <= '0;
            oCsrWEd    <= 1'b0;
            oCsrREq    <= 1'b0;
            oBulkAdrs  <= '0;
            oBulkWd    <= '0;
            oBulkWEd   <= 1'b0;
            oBulkVd    <= 1'b0;
            oErr       <= 2'd0;
        end else begin
            oCsrWEd  <= 1'b0;
            oCsrREq  <= 1'b0;
            oBulkWEd <= 1'b0;
            if (iErrClr) oErr <= 2'd0;
            if (csRise && state != sIdle) begin
                state      <= sIdle;
                oBulkVd    <= 1'b0;
                oSpiMisoEn <= 1'b0;
                rdPend     <= 1'b0;
                rdFirst    <= 1'b0;
            end else begin
                case (state)
                    sIdle: if (csFall) begin
                        state  <= sAdrs;
                        bitCnt <= '0;
                    end
                    sAdrs, sCmd, sLen, sDummy: if (sampleEdge) begin
                        sr     <= srNext;
                        bitCnt <= bitCnt + 6'd1;
                        if (fieldLast) begin
                            bitCnt <= '0;
                            case (state)
                                sAdrs: begin
                                    frameAdrs <= srNext[pAdrsBits-1:0];
                                    state     <= sCmd;
                                end
                                sCmd: begin
                                    cmd   <= srNext[7:0];
                                    state <= sLen;
                                end
                                sDummy: begin
                                    state   <= payState;
                                    oBulkVd <= (payState == sBulk);
                                end
                                default: begin
                                    lenCnt   <= lenField;
                                    bulkAdrs <= frameAdrs;
                                    byteIdx  <= '0;
                                    payState <= hdrNext;
                                    if (hdrNext == sDrain) state <= sDrain;
                                    else state <= (pDummyBytes > 0) ? sDummy : hdrNext;
                                    oBulkVd <= (pDummyBytes == 0) && (hdrNext == sBulk);
                                    if (hdrErr != 2'd0) oErr <= hdrErr;
                                    if (hdrNext == sCsrRd) begin
                                        oCsrREq  <= 1'b1;
                                        oCsrAdrs <= frameAdrs;
                                        rdPend   <= 1'b1;
                                        rdFirst  <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                    sCsrWr: if (sampleEdge) begin
                        sr     <= srNext;
                        bitCnt <= bitCnt + 6'd1;
                        if (fieldLast) begin
                            oCsrAdrs <= frameAdrs;
                            oCsrWd   <= srNext;
                            oCsrWEd  <= 1'b1;
                            state    <= sDrain;
                        end
                    end
                    // First shift edge only confirms bit 31 is on the wire; later ones advance
                    sCsrRd: if (shiftEdge) begin
                        if (rdFirst) begin
                            rdFirst <= 1'b0;
                            if (rdPend && !iCsrREd) begin
                                rdPend     <= 1'b0;
                                oSpiMisoEn <= 1'b1;
                                misoSr     <= '0;
                                oErr       <= 2'd3;
                            end
                        end else begin
                            misoSr <= {misoSr[30:0], 1'b0};
                        end
                    end
                    sBulk: if (sampleEdge) begin
                        sr     <= srNext;
                        bitCnt <= bitCnt + 6'd1;
                        if (bitCnt[2:0] == 3'd7) begin
                            lenCnt  <= lenCnt - 16'd1;
                            byteIdx <= byteIdx + 2'd1;
                            if (byteIdx == kWordLast || lenCnt == 16'd1) begin
                                oBulkWEd  <= 1'b1;
                                oBulkAdrs <= bulkAdrs;
                                oBulkWd   <= bulkWord;
                                bulkAdrs  <= bulkAdrs + kAdrsStep;
                                byteIdx   <= '0;
                            end
                            if (lenCnt == 16'd1) state <= sDrain;
                        end
                    end
                    sDrain: begin
                        oBulkVd    <= 1'b0;
                        oSpiMisoEn <= 1'b0;
                    end
                    default: state <= sIdle;
                endcase
                if (rdPend && iCsrREd) begin
                    misoSr     <= iCsrRd;
                    oSpiMisoEn <= 1'b1;
                    rdPend     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_cmd_engine.sv
// Scoreboard bench: dutA runs mode 0, dutB runs mode 3. Expected bus
// strobes are queued by the stimulus and popped by a negedge monitor.
module tb_spi_slave_cmd_engine;

    localparam int HALF = 80;

    logic iSysClk = 1'b0;
    logic iSysRst = 1'b0;
    always #5 iSysClk = ~iSysClk;

    logic        aSck = 1'b0, aCs = 1'b1, aMosi = 1'b0, aMiso, aMisoEn;
    logic [31:0] aCsrAdrs, aCsrWd, aBulkAdrs, aBulkWd;
    logic        aCsrWEd, aCsrREq, aBulkWEd, aBulkVd;
    logic [31:0] aCsrRd = 32'd0;
    logic        aCsrREd = 1'b0, aErrClr = 1'b0;
    logic [1:0]  aErr;

    logic        bSck = 1'b1, bCs = 1'b1, bMosi = 1'b0, bMiso, bMisoEn;
    logic [31:0] bCsrAdrs, bCsrWd, bBulkAdrs, bBulkWd;
    logic        bCsrWEd, bCsrREq, bBulkWEd, bBulkVd;
    logic [31:0] bCsrRd = 32'd0;
    logic        bCsrREd = 1'b0, bErrClr = 1'b0;
    logic [1:0]  bErr;

    spi_slave_cmd_engine dutA (
        .iSysClk(iSysClk), .iSysRst(iSysRst), .iSpiSck(aSck), .iSpiCs(aCs), .iSpiMosi(aMosi),
        .oSpiMiso(aMiso), .oSpiMisoEn(aMisoEn), .oCsrAdrs(aCsrAdrs), .oCsrWd(aCsrWd),
        .oCsrWEd(aCsrWEd), .oCsrREq(aCsrREq), .iCsrRd(aCsrRd), .iCsrREd(aCsrREd),
        .oBulkAdrs(aBulkAdrs), .oBulkWd(aBulkWd), .oBulkWEd(aBulkWEd), .oBulkVd(aBulkVd),
        .oErr(aErr), .iErrClr(aErrClr));

    spi_slave_cmd_engine #(.pCpol(1), .pCpha(1)) dutB (
        .iSysClk(iSysClk), .iSysRst(iSysRst), .iSpiSck(bSck), .iSpiCs(bCs), .iSpiMosi(bMosi),
        .oSpiMiso(bMiso), .oSpiMisoEn(bMisoEn), .oCsrAdrs(bCsrAdrs), .oCsrWd(bCsrWd),
        .oCsrWEd(bCsrWEd), .oCsrREq(bCsrREq), .iCsrRd(bCsrRd), .iCsrREd(bCsrREd),
        .oBulkAdrs(bBulkAdrs), .oBulkWd(bBulkWd), .oBulkWEd(bBulkWEd), .oBulkVd(bBulkVd),
        .oErr(bErr), .iErrClr(bErrClr));

    int nVec = 0;
    int nMis = 0;
    logic [7:0]  txq[$];
    logic [63:0] csrQ[$];
    logic [63:0] bulkQ[$];
    logic [31:0] rdQA[$];
    logic [31:0] rdQB[$];
    logic [31:0] misoWord;
    int          bitIdx;

    task automatic cmp(input string name, input logic [159:0] act, input logic [159:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        nVec++;
        nMis++;
        $display("FAIL %s: got a strobe, expected none", name);
    endtask

    function automatic logic [159:0] outsA();
        return {aMiso, aMisoEn, aCsrAdrs, aCsrWd, aCsrWEd, aCsrREq,
                aBulkAdrs, aBulkWd, aBulkWEd, aBulkVd, aErr};
    endfunction

    function automatic logic [159:0] outsB();
        return {bMiso, bMisoEn, bCsrAdrs, bCsrWd, bCsrWEd, bCsrREq,
                bBulkAdrs, bBulkWd, bBulkWEd, bBulkVd, bErr};
    endfunction

    task automatic hdr(input logic [31:0] adrs, input logic [7:0] c, input logic [15:0] len);
        txq.push_back(adrs[31:24]);
        txq.push_back(adrs[23:16]);
        txq.push_back(adrs[15:8]);
        txq.push_back(adrs[7:0]);
        txq.push_back(c);
        txq.push_back(len[15:8]);
        txq.push_back(len[7:0]);
        txq.push_back(8'h00);
    endtask

    task automatic word(input logic [31:0] w);
        txq.push_back(w[31:24]);
        txq.push_back(w[23:16]);
        txq.push_back(w[15:8]);
        txq.push_back(w[7:0]);
    endtask

    // SPI master: mode 0 on dutA, mode 3 on dutB; MISO bits after the 8-byte header go to misoWord
    task automatic spiSend(input bit useB, input bit startCs, input bit endCs);
        logic [7:0] b;
        if (startCs) begin
            misoWord = '0;
            bitIdx   = 0;
            if (useB) bCs = 1'b0; else aCs = 1'b0;
            #(HALF);
        end
        for (int i = 0; i < txq.size(); i++) begin
            b = txq[i];
            for (int k = 7; k >= 0; k--) begin
                if (!useB) begin
                    aMosi = b[k];
                    #(HALF);
                    if (bitIdx >= 64) misoWord = {misoWord[30:0], aMiso};
                    aSck = 1'b1;
                    #(HALF);
                    aSck = 1'b0;
                end else begin
                    bSck  = 1'b0;
                    bMosi = b[k];
                    #(HALF);
                    if (bitIdx >= 64) misoWord = {misoWord[30:0], bMiso};
                    bSck = 1'b1;
                    #(HALF);
                end
                bitIdx++;
            end
        end
        txq.delete();
        if (endCs) begin
            #(HALF);
            if (useB) bCs = 1'b1; else aCs = 1'b1;
            #(4 * HALF);
        end
    endtask

    task automatic clrErrA();
        @(negedge iSysClk);
        aErrClr = 1'b1;
        @(negedge iSysClk);
        aErrClr = 1'b0;
    endtask

    // Monitor: every strobe pops its expectation
    always @(negedge iSysClk) begin
        if (aCsrWEd) begin
            if (csrQ.size() == 0) unexpected("a_csr_wr");
            else cmp("a_csr_wr", {aCsrAdrs, aCsrWd}, csrQ.pop_front());
        end
        if (aBulkWEd) begin
            if (bulkQ.size() == 0) unexpected("a_bulk");
            else cmp("a_bulk", {aBulkVd, aBulkAdrs, aBulkWd}, {1'b1, bulkQ.pop_front()});
        end
        if (aCsrREq) begin
            if (rdQA.size() == 0) unexpected("a_rd_req");
            else cmp("a_rd_req", aCsrAdrs, rdQA.pop_front());
        end
        if (bCsrREq) begin
            if (rdQB.size() == 0) unexpected("b_rd_req");
            else cmp("b_rd_req", bCsrAdrs, rdQB.pop_front());
        end
        if (bCsrWEd || bBulkWEd) unexpected("b_wr");
    end

    // CSR read responder for dutB: data three cycles after the request
    initial begin
        forever begin
            @(negedge iSysClk);
            if (bCsrREq) begin
                repeat (3) @(negedge iSysClk);
                bCsrRd  = 32'hA5C3_0F96;
                bCsrREd = 1'b1;
                @(negedge iSysClk);
                bCsrREd = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        iSysRst = 1'b0;
        repeat (3) @(negedge iSysClk);
        cmp("a_reset_outs", outsA(), '0);
        cmp("b_reset_outs", outsB(), '0);
        iSysRst = 1'b1;
        repeat (8) @(negedge iSysClk);

        // CSR write, mode 0
        csrQ.push_back({32'h8765_0304, 32'h0000_000F});
        hdr(32'h8765_0304, 8'h01, 16'h0004);
        word(32'h0000_000F);
        spiSend(0, 1, 1);
        cmp("a_err_after_wr", aErr, 2'd0);

        // Bulk 10 bytes, partial last word
        bulkQ.push_back({32'h0000_1000, 32'h0102_0304});
        bulkQ.push_back({32'h0000_1004, 32'h0506_0708});
        bulkQ.push_back({32'h0000_1008, 32'h090A_0000});
        hdr(32'h0000_1000, 8'h03, 16'd10);
        for (int i = 1; i <= 10; i++) txq.push_back(8'(i));
        spiSend(0, 1, 1);
        cmp("a_vd_after_bulk", aBulkVd, 1'b0);

        // Length over pMaxLen, clear, bad command
        hdr(32'h0000_2000, 8'h03, 16'h0801);
        txq.push_back(8'h55);
        txq.push_back(8'h66);
        spiSend(0, 1, 1);
        cmp("a_err_badlen", aErr, 2'd2);
        clrErrA();
        cmp("a_err_clr", aErr, 2'd0);
        hdr(32'h0000_2000, 8'h07, 16'h0004);
        spiSend(0, 1, 1);
        cmp("a_err_badcmd", aErr, 2'd1);
        clrErrA();
        cmp("a_err_clr2", aErr, 2'd0);

        // Bulk length 0: no strobes, no error
        hdr(32'h0000_3000, 8'h03, 16'h0000);
        txq.push_back(8'hFF);
        txq.push_back(8'hFF);
        spiSend(0, 1, 1);
        cmp("a_err_len0", aErr, 2'd0);

        // CS raised after 6 of 8 bulk bytes
        bulkQ.push_back({32'h0000_2000, 32'hA1A2_A3A4});
        hdr(32'h0000_2000, 8'h03, 16'd8);
        for (int i = 1; i <= 6; i++) txq.push_back(8'hA0 + 8'(i));
        spiSend(0, 1, 1);
        cmp("a_vd_after_abort", aBulkVd, 1'b0);
        csrQ.push_back({32'h1122_3344, 32'hCAFE_BABE});
        hdr(32'h1122_3344, 8'h01, 16'h0004);
        word(32'hCAFE_BABE);
        spiSend(0, 1, 1);

        // Mode 3 CSR read
        rdQB.push_back(32'h0000_0010);
        hdr(32'h0000_0010, 8'h02, 16'h0004);
        word(32'h0000_0000);
        spiSend(1, 1, 0);
        cmp("b_misoen_before_cs", bMisoEn, 1'b1);
        #(HALF);
        bCs = 1'b1;
        #(4 * HALF);
        cmp("b_misoen_after_cs", bMisoEn, 1'b0);
        cmp("b_miso_word", misoWord, 32'hA5C3_0F96);
        cmp("b_err_read", bErr, 2'd0);

        // Mode 0 read with no response: zeros and read-late error
        rdQA.push_back(32'h0000_0020);
        hdr(32'h0000_0020, 8'h02, 16'h0004);
        word(32'hFFFF_FFFF);
        spiSend(0, 1, 1);
        cmp("a_err_late", aErr, 2'd3);
        cmp("a_miso_late", misoWord, 32'h0000_0000);
        clrErrA();

        // Reset in the middle of a bulk frame
        bulkQ.push_back({32'h0000_3000, 32'hB1B2_B3B4});
        hdr(32'h0000_3000, 8'h03, 16'd8);
        for (int i = 1; i <= 6; i++) txq.push_back(8'hB0 + 8'(i));
        spiSend(0, 1, 0);
        @(negedge iSysClk);
        cmp("a_vd_before_rst", aBulkVd, 1'b1);
        iSysRst = 1'b0;
        @(negedge iSysClk);
        cmp("a_rst_outs", outsA(), '0);
        iSysRst = 1'b1;
        txq.push_back(8'hB7);
        txq.push_back(8'hB8);
        spiSend(0, 0, 1);
        csrQ.push_back({32'h0000_0040, 32'h5A5A_0001});
        hdr(32'h0000_0040, 8'h01, 16'h0004);
        word(32'h5A5A_0001);
        spiSend(0, 1, 1);

        repeat (10) @(negedge iSysClk);
        cmp("csr_q_left", csrQ.size(), 0);
        cmp("bulk_q_left", bulkQ.size(), 0);
        cmp("rd_q_left", rdQA.size() + rdQB.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
